button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end conditioning stage for the board push-buttons: synchronises each raw button into `clk`, debounces it with a per-button stability counter, and produces a clean level plus single-cycle press/release pulses. It sits directly upstream of the run/step/stop control FSM, which consumes `button_press` as one-shot commands instead of raw levels.

## Interface
- `N_BUTTONS`, 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronised cycles required to accept a level change. Must be ≥ 1.
- `REPEAT_DELAY`, 50_000_000: cycles from an accepted press to the first auto-repeat pulse. Used only with `BUTTON_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent auto-repeat pulses. Used only with `BUTTON_AUTOREPEAT_EN`.
- `clk  in  1`: single system clock.
- `resetn  in  1`: reset, asynchronous and active-low.
- `button_raw  in  N_BUTTONS`: raw, asynchronous, active-high button inputs.
- `button_level  out  N_BUTTONS`: debounced level.
- `button_press  out  N_BUTTONS`: one-cycle pulse on each accepted press, and on each auto-repeat when enabled.
- `button_release  out  N_BUTTONS`: one-cycle pulse on each accepted release.

## Operation
- All channels are identical and fully independent. Simultaneous activity on several buttons is handled per channel with no priority.
- **Synchroniser:** 2-flop chain `sync1` → `sync2`, reset to 0.
- **Debounce:**
  - Each channel holds a `stable` bit, which drives `button_level`, and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sync2 == stable`, the counter clears to 0.
  - Otherwise the counter increments. When it would reach `DEBOUNCE_CYCLES`, `stable` toggles and the counter clears.
  - Any bounce back to `stable` before the threshold clears the counter. Glitches shorter than `DEBOUNCE_CYCLES` cycles are invisible.
- **Pulses:**
  - `button_press` is asserted in the same cycle that `button_level` first reads 1, for exactly one cycle.
  - `button_release` is asserted in the same cycle that `button_level` first reads 0, for exactly one cycle.
  - Both outputs are registered. No combinational path from `button_raw` to any output.
- **Reset:**
  - Asserting `resetn` low, at any time, immediately clears `sync1`, `sync2`, `stable`, all counters and all outputs to 0. No release pulse is generated.
  - A button held through reset is reported as a fresh press after the normal latency once `resetn` deasserts.

## Timing
- Latency: a clean raw edge that is captured at rising edge k gives `sync2` updated at edge k+1. `button_level` and the pulse then change at edge k+1+`DEBOUNCE_CYCLES`.
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` cycles of stable `sync2`.
- Minimum spacing between a press pulse and a release pulse on one channel is `DEBOUNCE_CYCLES` cycles.
- Outputs are 0 throughout reset and in the first cycle after deassertion.
- Auto-repeat, when enabled:
  - The press pulse at cycle P is followed by repeat pulses at P+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles while `button_level` stays 1.
  - A repeat due in the same cycle that `button_level` falls is suppressed. Only `button_release` fires.

## Configuration
- `BUTTON_AUTOREPEAT_EN` defined:
  - Each channel gets a repeat counter of width `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)`.
  - The counter clears on press, release and reset.
  - Additional `button_press` pulses are generated per the Timing section.
- `BUTTON_AUTOREPEAT_EN` undefined:
  - No repeat counter is built.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.
  - Exactly one `button_press` pulse per accepted press.

## Structure
- Shared package `button_pkg`:
  - Button index constants: `BTN_UP`=0, `BTN_LEFT`=1, `BTN_RIGHT`=2, `BTN_DOWN`=3.
  - Default `DEBOUNCE_CYCLES`, `REPEAT_DELAY`, `REPEAT_PERIOD` values for the 100 MHz board clock.
  - Used by the control FSM to index `button_press`.
- Sub-module `button_conditioner_ch`:
  - Handles one channel: synchroniser, debounce counter, edge pulses and optional repeat logic.
  - Instantiated `N_BUTTONS` times by a generate loop in `button_conditioner`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `N_BUTTONS`=4.
- **Clean press:** raw[0] 0→1 captured at edge 10, held → `button_level[0]`=1 and `button_press[0]`=1 at edge 15 only. Other channels stay 0.
- **Bounce:** raw[1] toggles 1,0,1,0 every 2 cycles, then holds 1 → no pulse during the bounce. A single press pulse fires 5 cycles after the final rising capture.
- **Glitch:** raw[2] is high for 3 cycles → `button_level[2]` and `button_press[2]` never assert.
- **Release and simultaneity:** raw[0] and raw[3] rise in the same cycle, then fall 20 cycles later → the two channels' press pulses coincide and their release pulses coincide. Exactly one of each per channel.
- **Reset mid-hold:** raw[1] held with `button_level[1]`=1, then `resetn` low for 3 cycles → all outputs 0 immediately, with no release pulse. After deassertion, a press pulse follows 5 cycles later.
- **Auto-repeat (`BUTTON_AUTOREPEAT_EN` only):** hold raw[0] for 30 cycles after the press at P → press pulses at P, P+10, P+13, P+16, …. On release, a release pulse fires and no repeat pulse fires in that cycle.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: button index constants and 100 MHz board defaults for the button conditioner.
package button_pkg;
    localparam int BTN_UP    = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 2;
    localparam int BTN_DOWN  = 3;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int REPEAT_DELAY_DEF    = 50_000_000;
    localparam int REPEAT_PERIOD_DEF   = 10_000_000;

    function automatic int max_i(int a, int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/button_conditioner_ch.sv
// button_conditioner_ch: one channel - 2-flop sync, stability-counter debounce, press/release pulses.
// Auto-repeat of the press pulse is built only when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner_ch
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q, stable_q, stable_d;
    logic          press_q, press_d, rel_q, rel_d, hit;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        hit      = (sync2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d    = (sync2_q == stable_q || hit) ? '0 : cnt_q + 1'b1;
        stable_d = stable_q ^ hit;
        rel_d    = hit & stable_q;
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = $clog2(max_i(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          first_q, first_d, rep_hit;

    // a repeat landing on the falling edge is dropped: !hit while stable_q is high
    always_comb begin
        rep_hit = stable_q && !hit &&
                  ((rep_q + 1'b1) == (first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));
        rep_d   = (hit || rep_hit || !stable_q) ? '0 : rep_q + 1'b1;
        first_d = hit ? ~stable_q : (first_q & ~rep_hit);
        press_d = (hit & ~stable_q) | rep_hit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rep_q   <= '0;
            first_q <= 1'b0;
        end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
        end
    end
`else
    assign press_d = hit & ~stable_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_BUTTONS independent debounced channels with press/release one-shots.
// Optional auto-repeat on button_press via BUTTON_AUTOREPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_BUTTONS-1:0] button_raw,
    output logic [N_BUTTONS-1:0] button_level,
    output logic [N_BUTTONS-1:0] button_press,
    output logic [N_BUTTONS-1:0] button_release
);
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_conditioner_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .resetn   (resetn),
            .raw_i    (button_raw[i]),
            .level_o  (button_level[i]),
            .press_o  (button_press[i]),
            .release_o(button_release[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce latency, bounce/glitch rejection, pulses, reset.
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] raw, lvl, press, rel;
    logic [31:0] acc;
    int passes = 0, fails = 0, total = 0;
    int pc[4], rc[4];
    int p0, p3, r0, r3, r1;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int SIM_PRESSES = 5;
`else
    localparam int SIM_PRESSES = 1;
`endif

    button_conditioner #(
        .N_BUTTONS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .resetn(resetn), .button_raw(raw),
        .button_level(lvl), .button_press(press), .button_release(rel)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 4; i++) begin pc[i] = 0; rc[i] = 0; end

    always @(negedge clk)
        for (int i = 0; i < 4; i++) begin
            pc[i] += int'(press[i]);
            rc[i] += int'(rel[i]);
        end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        raw    = 4'b0;
        step(2);
        chk("rst_outputs", {lvl, press, rel}, 0);
        resetn = 1'b1;
        step(1);
        chk("post_rst_outputs", {lvl, press, rel}, 0);

        raw[0] = 1'b1;
        step(5);
        chk("press_early_lvl", lvl, 4'b0000);
        step(1);
        chk("press_lvl", lvl, 4'b0001);
        chk("press_pulse", press, 4'b0001);
        step(1);
        chk("press_one_cycle", press, 4'b0000);
        chk("press_lvl_held", lvl, 4'b0001);

        raw[0] = 1'b0;
        step(5);
        chk("rel_early_lvl", lvl, 4'b0001);
        step(1);
        chk("rel_lvl", lvl, 4'b0000);
        chk("rel_pulse", rel, 4'b0001);
        step(1);
        chk("rel_one_cycle", rel, 4'b0000);

        acc = 0;
        for (int i = 0; i < 4; i++) begin
            raw[1] = ~i[0];
            repeat (2) begin step(1); acc |= 32'(press | rel | lvl); end
        end
        chk("bounce_quiet", acc, 0);
        raw[1] = 1'b1;
        step(5);
        chk("bounce_early_lvl", lvl, 4'b0000);
        step(1);
        chk("bounce_press", press, 4'b0010);
        chk("bounce_lvl", lvl, 4'b0010);
        step(1);
        chk("bounce_one_cycle", press, 4'b0000);

        acc = 0;
        raw[2] = 1'b1;
        repeat (3) begin step(1); acc |= 32'({lvl[2], press[2]}); end
        raw[2] = 1'b0;
        repeat (10) begin step(1); acc |= 32'({lvl[2], press[2]}); end
        chk("glitch_invisible", acc, 0);

        p0 = pc[0]; p3 = pc[3]; r0 = rc[0]; r3 = rc[3];
        raw[0] = 1'b1; raw[3] = 1'b1;
        step(5);
        chk("sim_early_lvl", lvl, 4'b0010);
        step(1);
        chk("sim_press", press & 4'b1001, 4'b1001);
        chk("sim_lvl", lvl, 4'b1011);
        step(14);
        raw[0] = 1'b0; raw[3] = 1'b0;
        step(5);
        chk("sim_rel_early", rel, 4'b0000);
        step(1);
        chk("sim_rel", rel, 4'b1001);
        chk("sim_rel_lvl", lvl, 4'b0010);
        step(4);
        chk("sim_press_cnt", 32'((pc[0] - p0) * 256 + (pc[3] - p3)), 32'(SIM_PRESSES * 256 + SIM_PRESSES));
        chk("sim_rel_cnt", 32'((rc[0] - r0) * 256 + (rc[3] - r3)), 32'(257));

        r1 = rc[1];
        chk("hold_lvl", lvl, 4'b0010);
        resetn = 1'b0;
        #1;
        chk("rst_mid_immediate", {lvl, press, rel}, 0);
        acc = 0;
        repeat (3) begin step(1); acc |= 32'({lvl, press, rel}); end
        chk("rst_mid_quiet", acc, 0);
        resetn = 1'b1;
        step(1);
        chk("rst_mid_first_cycle", {lvl, press, rel}, 0);
        step(4);
        chk("rst_repress_early", lvl, 4'b0000);
        step(1);
        chk("rst_repress", press, 4'b0010);
        chk("rst_repress_lvl", lvl, 4'b0010);
        chk("rst_no_release", 32'(rc[1] - r1), 0);
        raw[1] = 1'b0;
        step(8);
        chk("final_lvl", lvl, 4'b0000);

`ifdef BUTTON_AUTOREPEAT_EN
        raw[0] = 1'b1;
        step(6);
        chk("rep_first_press", press, 4'b0001);
        acc = 0;
        for (int i = 1; i <= 16; i++) begin step(1); acc[i] = press[0]; end
        chk("rep_pattern", acc, 32'h0001_2400);
        raw[0] = 1'b0;
        step(5);
        chk("rep_rel_early", rel, 4'b0000);
        step(1);
        chk("rep_rel", rel, 4'b0001);
        chk("rep_suppressed", press, 4'b0000);
        step(4);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
